// File: rtl/emif_cal_seq_ctrl_pkg.sv
// Shared types and CSR constants for the EMIF reset/calibration sequencer.
// Status layout is a packed struct so the read mux and any checker agree on bit positions.
package emif_seq_pkg;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        ASSERT_RST = 3'd1,
        WAIT_CAL   = 3'd2,
        EVAL       = 3'd3,
        DONE       = 3'd4
    } t_seq_state;

    localparam logic [15:0] EMIF_DFH_OFFSET        = 16'h0000;
    localparam logic [15:0] EMIF_STATUS_OFFSET     = 16'h0008;
    localparam logic [15:0] EMIF_CAPABILITY_OFFSET = 16'h0010;

    localparam logic [63:0] EMIF_DFH_VAL = 64'h3_00000_00B000_1009;

    localparam int STATUS_CH_W = 8;

    typedef struct packed {
        logic [30:0]            rsvd_63_33;
        logic                   seq_done;
        logic                   busy;
        logic [4:0]             rsvd_30_26;
        logic [1:0]             retry_cnt;
        logic [STATUS_CH_W-1:0] timeout;
        logic [STATUS_CH_W-1:0] fail;
        logic [STATUS_CH_W-1:0] success;
    } t_emif_status;

endpackage

// File: rtl/emif_cal_chan_tracker.sv
// Per-channel calibration result latch: first report wins within an attempt,
// fail beats success in the same cycle, timeout marks whatever is still unresolved.
module emif_cal_chan_tracker #(
    parameter int NUM_MEM_CH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear_status,
    input  logic                  clear_resolved,
    input  logic                  track_en,
    input  logic                  timeout_hit,
    input  logic [NUM_MEM_CH-1:0] cal_success,
    input  logic [NUM_MEM_CH-1:0] cal_fail,
    output logic [NUM_MEM_CH-1:0] ch_success,
    output logic [NUM_MEM_CH-1:0] ch_fail,
    output logic [NUM_MEM_CH-1:0] ch_timeout,
    output logic                  all_resolved
);

    logic [NUM_MEM_CH-1:0] resolved;
    logic [NUM_MEM_CH-1:0] hit;
    logic [NUM_MEM_CH-1:0] expire;

    // A channel reporting on the timeout cycle keeps its real result.
    always_comb begin
        hit    = '0;
        expire = '0;
        if (track_en) begin
            hit = ~resolved & (cal_success | cal_fail);
            if (timeout_hit) begin
                expire = ~resolved & ~hit;
            end
        end
    end

    assign all_resolved = &resolved;

    always_ff @(posedge clk) begin
        if (rst || clear_status) begin
            resolved   <= '0;
            ch_success <= '0;
            ch_fail    <= '0;
            ch_timeout <= '0;
        end else begin
            if (clear_resolved) begin
                resolved <= '0;
            end else begin
                resolved <= resolved | hit | expire;
            end
            ch_fail    <= ch_fail | (hit & cal_fail);
            ch_success <= ch_success | (hit & ~cal_fail);
            ch_timeout <= ch_timeout | expire;
        end
    end

endmodule

// File: rtl/emif_cal_seq_ctrl.sv
// EMIF channel reset and calibration sequencer with retry/timeout and a small CSR window
// (DFH, status, capability). Sequencing starts by itself after rst; a status write restarts it.
module emif_cal_seq_ctrl
    import emif_seq_pkg::*;
#(
    parameter int NUM_MEM_CH  = 4,
    parameter int RST_HOLD    = 16,
    parameter int CAL_TIMEOUT = 1000000,
    parameter int MAX_RETRY   = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic [NUM_MEM_CH-1:0] mem_rst_out,
    input  logic [NUM_MEM_CH-1:0] cal_success,
    input  logic [NUM_MEM_CH-1:0] cal_fail,
    input  logic                  csr_wr_en,
    input  logic                  csr_rd_en,
    input  logic [15:0]           csr_addr,
    input  logic [63:0]           csr_wr_data,
    output logic                  csr_rd_valid,
    output logic [63:0]           csr_rd_data,
    output logic                  seq_done,
    output t_seq_state            dbg_state
);

    localparam int HOLD_W = $clog2(RST_HOLD);
    localparam int TMO_W  = (CAL_TIMEOUT > 1) ? $clog2(CAL_TIMEOUT) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD - 1);
    localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(CAL_TIMEOUT - 1);
    localparam logic [1:0]        RETRY_MAX = 2'(MAX_RETRY);
    localparam logic [63:0] CAP_VAL = {24'h0, 8'(MAX_RETRY), 24'h0, 8'((1 << NUM_MEM_CH) - 1)};

    t_seq_state        state;
    logic [HOLD_W-1:0] hold_cnt;
    logic [TMO_W-1:0]  tmo_cnt;
    logic [1:0]        retry_cnt;

    logic [NUM_MEM_CH-1:0] ch_success;
    logic [NUM_MEM_CH-1:0] ch_fail;
    logic [NUM_MEM_CH-1:0] ch_timeout;
    logic                  all_resolved;

    logic         soft_rst;
    logic         hold_last;
    logic         tmo_hit;
    logic         retry_go;
    t_emif_status status;
    logic         unused_bits;

    assign soft_rst  = csr_wr_en && (csr_addr[15:3] == EMIF_STATUS_OFFSET[15:3]) && csr_wr_data[0];
    assign hold_last = (state == ASSERT_RST) && (hold_cnt == HOLD_LAST);
    assign tmo_hit   = (state == WAIT_CAL) && (tmo_cnt == TMO_LAST);
    assign retry_go  = (state == EVAL) && (|{ch_fail, ch_timeout}) && (retry_cnt < RETRY_MAX);
    assign dbg_state = state;
    assign unused_bits = ^{csr_wr_data[63:1], csr_addr[2:0]};

    emif_cal_chan_tracker #(
        .NUM_MEM_CH(NUM_MEM_CH)
    ) u_tracker (
        .clk           (clk),
        .rst           (rst),
        .clear_status  (soft_rst || retry_go),
        .clear_resolved(hold_last),
        .track_en      (state == WAIT_CAL),
        .timeout_hit   (tmo_hit),
        .cal_success   (cal_success),
        .cal_fail      (cal_fail),
        .ch_success    (ch_success),
        .ch_fail       (ch_fail),
        .ch_timeout    (ch_timeout),
        .all_resolved  (all_resolved)
    );

    // Soft reset overrides whatever the sequencer is doing, including mid-hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            hold_cnt    <= '0;
            tmo_cnt     <= '0;
            retry_cnt   <= '0;
            mem_rst_out <= '1;
            seq_done    <= 1'b0;
        end else if (soft_rst) begin
            state       <= ASSERT_RST;
            hold_cnt    <= '0;
            retry_cnt   <= '0;
            mem_rst_out <= '1;
            seq_done    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    state       <= ASSERT_RST;
                    hold_cnt    <= '0;
                    mem_rst_out <= '1;
                end
                ASSERT_RST: begin
                    if (hold_last) begin
                        state       <= WAIT_CAL;
                        tmo_cnt     <= '0;
                        mem_rst_out <= '0;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                WAIT_CAL: begin
                    if (tmo_cnt != TMO_LAST) begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                    if (all_resolved || tmo_hit) begin
                        state <= EVAL;
                    end
                end
                EVAL: begin
                    if (retry_go) begin
                        state       <= ASSERT_RST;
                        retry_cnt   <= retry_cnt + 1'b1;
                        hold_cnt    <= '0;
                        mem_rst_out <= '1;
                    end else begin
                        state    <= DONE;
                        seq_done <= 1'b1;
                    end
                end
                DONE: begin
                    mem_rst_out <= '0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    always_comb begin
        status           = '0;
        status.success   = STATUS_CH_W'(ch_success);
        status.fail      = STATUS_CH_W'(ch_fail);
        status.timeout   = STATUS_CH_W'(ch_timeout);
        status.retry_cnt = retry_cnt;
        status.busy      = (state != DONE);
        status.seq_done  = seq_done;
    end

    // Registered read port: the mux sees pre-write state, so a same-cycle write is invisible.
    always_ff @(posedge clk) begin
        if (rst) begin
            csr_rd_valid <= 1'b0;
            csr_rd_data  <= '0;
        end else begin
            csr_rd_valid <= csr_rd_en;
            if (!csr_rd_en) begin
                csr_rd_data <= '0;
            end else if (csr_addr[15:3] == EMIF_DFH_OFFSET[15:3]) begin
                csr_rd_data <= EMIF_DFH_VAL;
            end else if (csr_addr[15:3] == EMIF_STATUS_OFFSET[15:3]) begin
                csr_rd_data <= status;
            end else if (csr_addr[15:3] == EMIF_CAPABILITY_OFFSET[15:3]) begin
                csr_rd_data <= CAP_VAL;
            end else begin
                csr_rd_data <= '0;
            end
        end
    end

endmodule

// File: tb/tb_emif_cal_seq_ctrl.sv
// Bench for emif_cal_seq_ctrl: directed CSR steps plus randomized per-attempt channel
// behaviour scored against an attempt-level model of the retry/timeout rules.
module tb_emif_cal_seq_ctrl;
    import emif_seq_pkg::*;

    localparam int NCH  = 4;
    localparam int HOLD = 16;
    localparam int TMO  = 100;
    localparam int MAXR = 2;

    logic             clk;
    logic             rst;
    logic [NCH-1:0]   mem_rst_out;
    logic [NCH-1:0]   cal_success;
    logic [NCH-1:0]   cal_fail;
    logic             csr_wr_en;
    logic             csr_rd_en;
    logic [15:0]      csr_addr;
    logic [63:0]      csr_wr_data;
    logic             csr_rd_valid;
    logic [63:0]      csr_rd_data;
    logic             seq_done;
    t_seq_state       dbg_state;

    int n_checks = 0;
    int n_pass   = 0;

    // Per attempt, per channel: 0 = never reports, 1 = success, 2 = fail, 3 = success+fail together.
    int plan_kind [3][NCH];
    int plan_dly  [3][NCH];
    logic [NCH-1:0] rst_at_a;
    logic [63:0]    last_exp;

    emif_cal_seq_ctrl #(
        .NUM_MEM_CH (NCH),
        .RST_HOLD   (HOLD),
        .CAL_TIMEOUT(TMO),
        .MAX_RETRY  (MAXR)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .mem_rst_out (mem_rst_out),
        .cal_success (cal_success),
        .cal_fail    (cal_fail),
        .csr_wr_en   (csr_wr_en),
        .csr_rd_en   (csr_rd_en),
        .csr_addr    (csr_addr),
        .csr_wr_data (csr_wr_data),
        .csr_rd_valid(csr_rd_valid),
        .csr_rd_data (csr_rd_data),
        .seq_done    (seq_done),
        .dbg_state   (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Attempt-level model: classify each channel per attempt, retry while anything is bad.
    function automatic logic [63:0] model_status(output int n_att);
        int retries;
        logic [7:0] s, f, t;
        retries = 0;
        n_att = 0;
        s = '0; f = '0; t = '0;
        for (int a = 0; a < 3; a++) begin
            s = '0; f = '0; t = '0;
            for (int ch = 0; ch < NCH; ch++) begin
                if (plan_kind[a][ch] == 0)      t[ch] = 1'b1;
                else if (plan_kind[a][ch] == 1) s[ch] = 1'b1;
                else                            f[ch] = 1'b1;
            end
            n_att = a + 1;
            if ((f | t) != 0 && retries < MAXR) retries++;
            else break;
        end
        return (64'(1) << 32) | (64'(retries) << 24) | (64'(t) << 16) | (64'(f) << 8) | 64'(s);
    endfunction

    task automatic plan_all(input int kind);
        for (int a = 0; a < 3; a++)
            for (int ch = 0; ch < NCH; ch++) begin
                plan_kind[a][ch] = kind;
                plan_dly[a][ch]  = $urandom_range(0, 60);
            end
    endtask

    task automatic plan_random();
        int r;
        for (int a = 0; a < 3; a++)
            for (int ch = 0; ch < NCH; ch++) begin
                r = $urandom_range(0, 9);
                plan_kind[a][ch] = (r < 6) ? 1 : (r < 8) ? 2 : (r == 8) ? 3 : 0;
                plan_dly[a][ch]  = $urandom_range(0, 60);
            end
    endtask

    // One CSR cycle; returns after the cycle following the response (rd_valid must be gone).
    task automatic csr_access(input bit rd, input bit wr, input logic [15:0] addr,
                              input logic [63:0] wdata, input logic [63:0] exp_rd, input string tag);
        csr_rd_en   = rd;
        csr_wr_en   = wr;
        csr_addr    = addr;
        csr_wr_data = wdata;
        @(posedge clk); #1;
        csr_rd_en = 1'b0;
        csr_wr_en = 1'b0;
        rst_at_a  = mem_rst_out;
        if (rd) begin
            chk({tag, "_valid"}, 64'(csr_rd_valid), 64'(1));
            chk(tag, csr_rd_data, exp_rd);
        end
        @(posedge clk); #1;
        if (rd) chk({tag, "_valid_drop"}, 64'(csr_rd_valid), 64'(0));
    endtask

    task automatic wait_pulse(input string tag, input int already_high);
        int hi, guard;
        hi = already_high;
        guard = 0;
        cal_success = '0;
        cal_fail    = '0;
        while (mem_rst_out != '0 && guard < 64) begin
            @(posedge clk); #1;
            guard++;
            if (mem_rst_out == '1) hi++;
        end
        chk({tag, "_rst_hold"}, 64'(hi), 64'(HOLD));
    endtask

    task automatic drive_attempt(input int att, output bit more);
        int a, c;
        a = (att > 2) ? 2 : att;
        c = 0;
        more = 1'b0;
        forever begin
            for (int ch = 0; ch < NCH; ch++) begin
                cal_success[ch] = (plan_kind[a][ch] == 1 || plan_kind[a][ch] == 3) && (c >= plan_dly[a][ch]);
                cal_fail[ch]    = (plan_kind[a][ch] >= 2) && (c >= plan_dly[a][ch]);
            end
            @(posedge clk); #1;
            c++;
            if (mem_rst_out != '0) begin more = 1'b1; break; end
            if (seq_done) break;
            if (c > 400) begin chk("cal_wait_bound", 64'(c), 64'(400)); break; end
        end
        cal_success = '0;
        cal_fail    = '0;
    endtask

    task automatic run_scenario(input string tag, input int already_high);
        int att, exp_att;
        bit more;
        att = 0;
        more = 1'b1;
        wait_pulse(tag, already_high);
        while (more) begin
            drive_attempt(att, more);
            att++;
            if (more) begin
                if (att > MAXR) begin
                    chk({tag, "_extra_attempt"}, 64'(att), 64'(MAXR));
                    more = 1'b0;
                end else begin
                    wait_pulse(tag, 1);
                end
            end
        end
        last_exp = model_status(exp_att);
        chk({tag, "_attempts"}, 64'(att), 64'(exp_att));
        chk({tag, "_seq_done"}, 64'(seq_done), 64'(1));
        chk({tag, "_mem_rst"}, 64'(mem_rst_out), 64'(0));
        chk({tag, "_state"}, 64'(dbg_state), 64'(DONE));
        csr_access(1'b1, 1'b0, 16'h0008, 64'h0, last_exp, {tag, "_status"});
    endtask

    initial begin
        rst = 1'b1;
        cal_success = '0;
        cal_fail    = '0;
        csr_wr_en   = 1'b0;
        csr_rd_en   = 1'b0;
        csr_addr    = '0;
        csr_wr_data = '0;
        rst_at_a    = '0;
        last_exp    = '0;

        repeat (3) @(posedge clk);
        #1;
        chk("reset_mem_rst", 64'(mem_rst_out), 64'hF);
        chk("reset_rd_valid", 64'(csr_rd_valid), 64'(0));
        chk("reset_rd_data", csr_rd_data, 64'h0);
        chk("reset_seq_done", 64'(seq_done), 64'(0));
        chk("reset_state", 64'(dbg_state), 64'(IDLE));
        rst = 1'b0;

        // Nominal: every channel succeeds 50 cycles into WAIT_CAL.
        plan_all(1);
        for (int ch = 0; ch < NCH; ch++) plan_dly[0][ch] = 50;
        run_scenario("nominal", 0);

        // CSR map, ignored writes, and low address bits being don't-care.
        csr_access(1'b1, 1'b0, 16'h0000, 64'h0, 64'h3_00000_00B000_1009, "rd_dfh");
        csr_access(1'b1, 1'b0, 16'h0010, 64'h0, 64'h0000_0002_0000_000F, "rd_cap");
        csr_access(1'b1, 1'b0, 16'h0018, 64'h0, 64'h0, "rd_unmapped");
        csr_access(1'b1, 1'b0, 16'h000C, 64'h0, last_exp, "rd_status_alias");
        csr_access(1'b0, 1'b1, 16'h0010, '1, 64'h0, "wr_cap");
        csr_access(1'b1, 1'b0, 16'h0010, 64'h0, 64'h0000_0002_0000_000F, "rd_cap_after_wr");
        csr_access(1'b0, 1'b1, 16'h0008, 64'hFFFF_FFFF_FFFF_FFFE, 64'h0, "wr_status_bit0_clr");
        csr_access(1'b1, 1'b0, 16'h0008, 64'h0, last_exp, "rd_status_unchanged");

        // Read and soft reset in the same cycle: the read sees the pre-write status.
        plan_all(1);
        plan_kind[0][2] = 2;
        csr_access(1'b1, 1'b1, 16'h0008, 64'h1, last_exp, "rdwr_pre_write");
        chk("rdwr_soft_rst_mem_rst", 64'(rst_at_a), 64'hF);
        run_scenario("fail_then_pass", 2);

        // Channel 3 never resolves on any attempt.
        plan_all(1);
        for (int a = 0; a < 3; a++) plan_kind[a][3] = 0;
        csr_access(1'b0, 1'b1, 16'h0008, 64'h1, 64'h0, "soft_rst_tmo");
        run_scenario("timeout", 2);

        // Simultaneous success+fail on ch0, then soft reset while still in WAIT_CAL.
        csr_access(1'b0, 1'b1, 16'h0008, 64'h1, 64'h0, "soft_rst_simul");
        wait_pulse("simul", 2);
        cal_success[0] = 1'b1;
        cal_fail[0]    = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        csr_access(1'b1, 1'b0, 16'h0008, 64'h0, 64'h0000_0000_8000_0100, "simul_fail_wins");
        csr_access(1'b0, 1'b1, 16'h0008, 64'h1, 64'h0, "soft_rst_wait_cal");
        chk("soft_rst_next_mem_rst", 64'(rst_at_a), 64'hF);
        csr_access(1'b1, 1'b0, 16'h0008, 64'h0, 64'h0000_0000_8000_0000, "soft_rst_status_clear");
        plan_random();
        run_scenario("rand_after_soft", 4);

        for (int i = 0; i < 6; i++) begin
            plan_random();
            csr_access(1'b0, 1'b1, 16'h0008, 64'h1, 64'h0, "soft_rst_rand");
            run_scenario($sformatf("rand%0d", i), 2);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
